// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and sizing helpers for the FIFO stream adapters
package fifo_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  // Legal FIFO read latencies are 1..3; zero is not a valid encoding.
  typedef logic [1:0] rd_lat_t;

  // One slot per in-flight read plus one for the word being presented.
  function automatic int buf_depth(input int rd_lat);
    return rd_lat + 1;
  endfunction

endpackage

// File: rtl/stream_buf.sv
// rtl/stream_buf.sv - small circular word buffer with push/pop and occupancy
module stream_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2,
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [OCC_W-1:0]  occ
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_data = mem[head];

  // Pointer and occupancy bookkeeping; a pop and a push in one cycle leave occ unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) tail <= wrap_inc(tail);
      if (pop)  head <= wrap_inc(head);
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  // The issuing side must never overfill or over-drain the buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && occ == OCC_W'(DEPTH)));
      assert (!(push && occ == OCC_W'(DEPTH)));
      assert (!(pop && occ == '0));
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - sync_fifo read-side adapter presenting words as a valid/ready stream
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  words_out,
  output logic              idle
);

  localparam int BUF_D = buf_depth(RD_LAT);
  localparam int OCC_W = $clog2(BUF_D + 1);

  logic [RD_LAT-1:0] pipe;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  inflight;
  logic [OCC_W:0]    demand;
  logic              pop;
  logic              land;

  assign pop     = m_valid & m_ready;
  assign land    = pipe[RD_LAT-1];
  assign m_valid = (occ != '0);
  assign idle    = (occ == '0) && (inflight == '0);

  // Count reads that are issued but whose data has not yet landed.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + OCC_W'(pipe[i]);
    end
  end

  // Every issued read owns a buffer slot, so a word can always land regardless of backpressure.
  assign demand     = {1'b0, occ} + {1'b0, inflight} - (OCC_W + 1)'(pop);
  assign fifo_rd_en = ~rst & en & ~fifo_empty & (demand < (OCC_W + 1)'(BUF_D));

  // Shift issued-read markers toward the tail in step with the FIFO read latency.
  always_ff @(posedge clk) begin
    if (rst) pipe <= '0;
    else     pipe <= (pipe << 1) | RD_LAT'(fifo_rd_en);
  end

  // Completed output handshakes, wrapping at the counter width.
  always_ff @(posedge clk) begin
    if (rst)      words_out <= '0;
    else if (pop) words_out <= words_out + 1'b1;
  end

  stream_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_D)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (land),
    .push_data (fifo_dout),
    .pop       (pop),
    .head_data (m_data),
    .occ       (occ)
  );

  // Reads into an empty FIFO would corrupt its pointers; the latency must be in range.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_rd_en && fifo_empty));
      assert (RD_LAT >= RD_LAT_MIN && RD_LAT <= RD_LAT_MAX);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - scoreboard bench for fifo_rd_stream with two latency configurations
module tb_fifo_rd_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance a: RD_LAT=1, CNT_W=4. Instance b: RD_LAT=2, CNT_W=32.
  logic        en_a = 1'b0, en_b = 1'b0;
  logic        rdy_a = 1'b0, rdy_b = 1'b0;
  logic        emp_a, emp_b, rd_a, rd_b, v_a, v_b, idle_a, idle_b;
  logic [15:0] dout_a, dout_b, d_a, d_b;
  logic [3:0]  wo_a;
  logic [31:0] wo_b;

  logic [1:0]  rdv, empv, mv, rdyv;
  logic [15:0] mdv [2];

  logic [15:0] mem [2][256];
  logic [7:0]  rp [2] = '{8'd0, 8'd0};
  logic [7:0]  wp [2];
  logic [15:0] dst [2][2];

  logic [15:0] exp_a [$];
  logic [15:0] exp_b [$];
  logic        hold [2] = '{1'b0, 1'b0};
  logic [15:0] hold_d [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_W(16), .RD_LAT(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .fifo_empty(emp_a), .fifo_rd_en(rd_a),
    .fifo_dout(dout_a), .m_valid(v_a), .m_ready(rdy_a), .m_data(d_a),
    .words_out(wo_a), .idle(idle_a)
  );

  fifo_rd_stream #(.DATA_W(16), .RD_LAT(2), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .fifo_empty(emp_b), .fifo_rd_en(rd_b),
    .fifo_dout(dout_b), .m_valid(v_b), .m_ready(rdy_b), .m_data(d_b),
    .words_out(wo_b), .idle(idle_b)
  );

  assign rdv    = {rd_b, rd_a};
  assign empv   = {emp_b, emp_a};
  assign mv     = {v_b, v_a};
  assign rdyv   = {rdy_b, rdy_a};
  assign mdv[0] = d_a;
  assign mdv[1] = d_b;
  assign emp_a  = (rp[0] == wp[0]);
  assign emp_b  = (rp[1] == wp[1]);
  assign dout_a = dst[0][0];
  assign dout_b = dst[1][1];

  // FIFO model: registered read, data valid RD_LAT cycles after the sampled strobe.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rdv[k]) begin
        dst[k][0] <= mem[k][rp[k]];
        rp[k]     <= rp[k] + 8'd1;
      end
      dst[k][1] <= dst[k][0];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input int k, input logic [15:0] val);
    mem[k][wp[k]] = val;
    wp[k] = wp[k] + 8'd1;
    if (k == 0) exp_a.push_back(val);
    else        exp_b.push_back(val);
  endtask

  task automatic sb_pop(input int k, input logic [15:0] got);
    logic [15:0] e;
    n_cmp++;
    if ((k == 0 && exp_a.size() == 0) || (k == 1 && exp_b.size() == 0)) begin
      n_bad++;
      $display("FAIL sb%0d_extra: got %h with no word expected", k, got);
    end else begin
      if (k == 0) e = exp_a.pop_front();
      else        e = exp_b.pop_front();
      if (got !== e) begin
        n_bad++;
        $display("FAIL sb%0d_data: got %h required %h", k, got, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pops on handshakes, hold stability under backpressure, no read when empty.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        hold[k] = 1'b0;
      end else begin
        if (rdv[k]) begin
          n_cmp++;
          if (empv[k]) begin
            n_bad++;
            $display("FAIL rd_when_empty%0d: fifo_rd_en=1 with fifo_empty=1, required fifo_rd_en=0", k);
          end
        end
        if (hold[k]) begin
          n_cmp++;
          if (!mv[k] || mdv[k] !== hold_d[k]) begin
            n_bad++;
            $display("FAIL hold%0d: valid=%0b data=%h required valid=1 data=%h", k, mv[k], mdv[k], hold_d[k]);
          end
        end
        if (mv[k] && rdyv[k]) sb_pop(k, mdv[k]);
        hold[k]   = mv[k] & ~rdyv[k];
        hold_d[k] = mdv[k];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t_rd, t_v, t_last, nv, nrd;
    logic       saw_wrap;
    logic [3:0] prev;

    wp[0] = 8'd0;
    wp[1] = 8'd0;
    rst = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check("rst_valid_a", v_a, 0);
    check("rst_words_a", wo_a, 0);
    check("rst_idle_a", idle_a, 1);
    check("rst_rd_a", rd_a, 0);
    check("rst_valid_b", v_b, 0);
    check("rst_words_b", wo_b, 0);
    check("rst_idle_b", idle_b, 1);
    step();
    rst = 1'b0;

    // Streaming at full rate with a ready sink.
    rdy_a = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(0, 16'(i));
    en_a = 1'b1;
    t_rd = -1; t_v = -1; t_last = -1; nv = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (rd_a && t_rd < 0) t_rd = c;
      if (v_a) begin
        if (t_v < 0) t_v = c;
        t_last = c;
        nv++;
      end
    end
    check("t1_latency", 32'(t_v - t_rd), 2);
    check("t1_valid_cycles", 32'(nv), 8);
    check("t1_no_bubble", 32'(t_last - t_v + 1), 8);
    check("t1_words", wo_a, 8);
    check("t1_idle", idle_a, 1);
    check("t1_fifo_empty", emp_a, 1);

    // Backpressure from the start: only BUF_D reads may be issued.
    step();
    en_a = 1'b0;
    rdy_a = 1'b0;
    for (int i = 0; i < 5; i++) push_word(0, 16'hA000 + 16'(i));
    en_a = 1'b1;
    nrd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rd_a) nrd++;
    end
    check("t2_rd_cycles", 32'(nrd), 2);
    check("t2_valid_held", v_a, 1);
    check("t2_data_held", d_a, 16'hA000);
    step();
    rdy_a = 1'b1;
    repeat (14) @(negedge clk);
    check("t2_words", wo_a, 13);
    check("t2_idle", idle_a, 1);

    // Enable dropped after two reads: in-flight words still drain.
    step();
    en_a = 1'b0;
    for (int i = 0; i < 4; i++) push_word(0, 16'hC000 + 16'(i));
    en_a = 1'b1;
    step();
    step();
    en_a = 1'b0;
    repeat (8) @(negedge clk);
    check("t4_words_partial", wo_a, 15);
    check("t4_idle_partial", idle_a, 1);
    check("t4_fifo_left", 32'(wp[0] - rp[0]), 2);
    step();
    en_a = 1'b1;
    repeat (8) @(negedge clk);
    check("t4_words_wrap", wo_a, 1);
    check("t4_idle_done", idle_a, 1);
    check("t4_fifo_empty", emp_a, 1);
    step();
    en_a = 1'b0;

    // RD_LAT=2 with a toggling sink.
    rdy_b = 1'b1;
    for (int i = 1; i <= 6; i++) push_word(1, 16'hB000 + 16'(i));
    en_b = 1'b1;
    for (int c = 0; c < 24; c++) begin
      rdy_b = (c % 2 == 0);
      step();
    end
    rdy_b = 1'b1;
    repeat (6) step();
    @(negedge clk);
    check("t3_words", wo_b, 6);
    check("t3_idle", idle_b, 1);
    check("t3_fifo_empty", emp_b, 1);

    // Reset with two words buffered and one in flight.
    step();
    en_b = 1'b0;
    rdy_b = 1'b0;
    for (int i = 0; i < 5; i++) push_word(1, 16'hD000 + 16'(i));
    en_b = 1'b1;
    repeat (4) step();
    check("t5_pre_valid", v_b, 1);
    check("t5_pre_idle", idle_b, 0);
    rst = 1'b1;
    push_word(0, 16'hEEEE);
    en_a = 1'b1;
    @(negedge clk);
    check("t5_rd_gated_a", rd_a, 0);
    check("t5_rd_gated_b", rd_b, 0);
    step();
    wp[0] = rp[0];
    wp[1] = rp[1];
    exp_a.delete();
    exp_b.delete();
    en_a = 1'b0;
    en_b = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("t5_valid", v_b, 0);
    check("t5_words", wo_b, 0);
    check("t5_idle", idle_b, 1);
    check("t5_words_a", wo_a, 0);
    check("t5_idle_a", idle_a, 1);

    // Counter wrap on the 4-bit instance.
    step();
    rdy_a = 1'b1;
    for (int i = 0; i < 17; i++) push_word(0, 16'h1000 + 16'(i));
    en_a = 1'b1;
    saw_wrap = 1'b0;
    prev = 4'd0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (prev == 4'd15 && wo_a == 4'd0) saw_wrap = 1'b1;
      prev = wo_a;
    end
    check("t6_saw_wrap", saw_wrap, 1);
    check("t6_words", wo_a, 1);
    check("t6_idle", idle_a, 1);

    check("sb_a_drained", exp_a.size(), 0);
    check("sb_b_drained", exp_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
